// File: rtl/wb_pkg.sv
// Shared widths, the buffered long-latency result record and the r0 write
// suppression rule for the writeback arbiter.
package wb_pkg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [AW-1:0] ZERO_REG = {AW{1'b0}};

    typedef struct packed {
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } wb_entry_t;

    // A selected write only reaches the register file when it does not target r0.
    function automatic logic wb_we(input logic sel, input logic [AW-1:0] waddr);
        return sel && (waddr != ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: pipeline results, long-latency results, issue tracking,
// decode busy queries and the register-file write port.
interface wb_arbiter_if;
    import wb_pkg::*;

    logic          pipe_we;
    logic [AW-1:0] pipe_waddr;
    logic [DW-1:0] pipe_wdata;
    logic          lu_valid;
    logic          lu_ready;
    logic [AW-1:0] lu_waddr;
    logic [DW-1:0] lu_wdata;
    logic          issue_valid;
    logic [AW-1:0] issue_waddr;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          rs_busy;
    logic          rt_busy;
    logic          stall_req;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  lu_valid, lu_waddr, lu_wdata,
        output lu_ready,
        input  issue_valid, issue_waddr, rs_addr, rt_addr,
        output rs_busy, rt_busy, stall_req,
        output rf_we, rf_waddr, rf_wdata
    );

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output lu_valid, lu_waddr, lu_wdata,
        input  lu_ready,
        output issue_valid, issue_waddr, rs_addr, rt_addr,
        input  rs_busy, rt_busy, stall_req,
        input  rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency results until they win the
// register-file write port. Full/empty derive from the registered count.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CAP      = CW'(DEPTH);

    logic [W-1:0]  mem_d [DEPTH];
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_d, wr_ptr_q;
    logic [PW-1:0] rd_ptr_d, rd_ptr_q;
    logic [CW-1:0] count_d, count_q;
    logic          push_ok_s, pop_ok_s;

    assign full  = (count_q == CAP);
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state for storage, wrapping pointers and occupancy.
    always_comb begin
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset flushes every entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Owns the single register-file write port: pipeline results win, buffered
// long-latency results fill idle slots, and a busy bitmap guards decode.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int NREG = 2 ** AW;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);

    wb_entry_t     fifo_din_s;
    wb_entry_t     fifo_dout_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;

    logic          sel_s;
    logic [AW-1:0] sel_waddr_s;
    logic [DW-1:0] sel_wdata_s;

    logic            rf_we_d, rf_we_q;
    logic [AW-1:0]   rf_waddr_d, rf_waddr_q;
    logic [DW-1:0]   rf_wdata_d, rf_wdata_q;
    logic            stall_req_d, stall_req_q;
    logic [NREG-1:0] busy_d, busy_q;
    logic [SW-1:0]   starve_d, starve_q;

    assign bus.lu_ready     = rst & ~fifo_full_s;
    assign fifo_push_s      = bus.lu_valid & bus.lu_ready;
    assign fifo_din_s.waddr = bus.lu_waddr;
    assign fifo_din_s.wdata = bus.lu_wdata;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(wb_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (fifo_din_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Fixed priority: the pipeline is never back-pressured, the FIFO head fills gaps.
    always_comb begin
        sel_s       = 1'b0;
        fifo_pop_s  = 1'b0;
        sel_waddr_s = rf_waddr_q;
        sel_wdata_s = rf_wdata_q;
        if (bus.pipe_we) begin
            sel_s       = 1'b1;
            sel_waddr_s = bus.pipe_waddr;
            sel_wdata_s = bus.pipe_wdata;
        end else if (!fifo_empty_s) begin
            sel_s       = 1'b1;
            fifo_pop_s  = 1'b1;
            sel_waddr_s = fifo_dout_s.waddr;
            sel_wdata_s = fifo_dout_s.wdata;
        end else begin
            sel_s = 1'b0;
        end
        rf_we_d    = wb_we(sel_s, sel_waddr_s);
        rf_waddr_d = sel_waddr_s;
        rf_wdata_d = sel_wdata_s;
    end

    // Busy bitmap: a new issue must win over a retiring entry for the same register.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop_s) begin
            busy_d[fifo_dout_s.waddr] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (bus.issue_valid && (bus.issue_waddr != ZERO_REG)) begin
            busy_d[bus.issue_waddr] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // Starvation: count cycles the head loses to the pipeline, saturating.
    always_comb begin
        if (fifo_empty_s || fifo_pop_s) begin
            starve_d = {SW{1'b0}};
        end else if (bus.pipe_we && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
        stall_req_d = (starve_q >= STARVE_LIM) | (fifo_count_s == DEPTH_CNT);
    end

    // Output, scoreboard and starvation registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= {AW{1'b0}};
            rf_wdata_q  <= {DW{1'b0}};
            stall_req_q <= 1'b0;
            busy_q      <= {NREG{1'b0}};
            starve_q    <= {SW{1'b0}};
        end else begin
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            stall_req_q <= stall_req_d;
            busy_q      <= busy_d;
            starve_q    <= starve_d;
        end
    end

    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.stall_req = stall_req_q;
    assign bus.rs_busy   = busy_q[bus.rs_addr];
    assign bus.rt_busy   = busy_q[bus.rt_addr];

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback arbiter that owns the single register-file write port.
- Merges in-order pipeline results with out-of-order results from the long-latency unit (mul/div) through a small FIFO.
- Keeps a per-register busy scoreboard so the decode stage can stall on pending long-latency writes.
- Outputs are registered at posedge; the register file commits them at the following negedge.

Parameters:
DW, 32, data width
AW, 5, register address width (2**AW registers)
FIFO_DEPTH, 2, long-latency result buffer entries (power of two, >=2)
STARVE_MAX, 4, consecutive cycles a FIFO head may lose arbitration before stall_req asserts

Ports:
clk  in  1  clock, posedge
rst  in  1  reset, synchronous, active-low
pipe_we  in  1  pipeline WB write request (never back-pressured)
pipe_waddr  in  AW  pipeline destination register
pipe_wdata  in  DW  pipeline result
lu_valid  in  1  long-latency result valid
lu_ready  out  1  FIFO can accept
lu_waddr  in  AW  long-latency destination register
lu_wdata  in  DW  long-latency result
issue_valid  in  1  long-latency op issued this cycle
issue_waddr  in  AW  its destination register
rs_addr  in  AW  decode source 1
rt_addr  in  AW  decode source 2
rs_busy  out  1  rs has a pending long-latency write
rt_busy  out  1  rt has a pending long-latency write
stall_req  out  1  request a pipeline bubble to drain the FIFO
rf_we  out  1  register-file write enable
rf_waddr  out  AW  register-file write address
rf_wdata  out  DW  register-file write data

Behaviour:
- Reset (rst=0 at posedge):
  - FIFO empty, busy bitmap cleared, starve counter 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0.
  - lu_ready is forced 0 combinationally while rst=0.
- Reset mid-operation discards all FIFO entries and pending busy bits. No write issues in the cycle after reset.
- Accepting long-latency results:
  - lu_ready = rst & !full. Full is decided from the registered count only, so a pop in the same cycle does not admit a push.
  - Push on lu_valid & lu_ready.
  - lu_* must be held stable while lu_valid=1 and lu_ready=0.
- Arbitration, each cycle:
  - If pipe_we=1, the pipeline wins and is selected.
  - Otherwise, if the FIFO is non-empty, the head is selected and popped.
  - Otherwise nothing is selected.
- Output registers:
  - Next cycle rf_we = selected & (waddr != 0). rf_waddr and rf_wdata take the selected values.
  - If nothing is selected, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
  - Pipeline latency is 1 cycle. Long-latency latency is at least 2 cycles (push, then pop); there is no FIFO bypass.
- Writes to r0 are suppressed, but a FIFO head addressed to r0 is still popped.
- Scoreboard (busy[2**AW-1:0]):
  - Set on issue_valid when issue_waddr != 0.
  - Cleared when a FIFO entry with that waddr is popped.
  - If set and clear hit the same address in the same cycle, set wins.
  - busy[0] is constant 0.
  - rs_busy = busy[rs_addr] and rt_busy = busy[rt_addr], combinational from registered state.
  - Issuing to an already-busy register is illegal; decode must stall on rs_busy/rt_busy/dest busy.
- Starvation:
  - The counter increments when the FIFO is non-empty and pipe_we=1, and resets to 0 on any pop or when the FIFO is empty. It saturates at STARVE_MAX.
  - stall_req = (count >= STARVE_MAX) | full, registered.
  - The front end responds by deasserting pipe_we for at least one cycle.
- Ordering:
  - FIFO entries retire in push order.
  - The pipeline may overtake buffered entries; the scoreboard prevents WAW/RAW hazards on busy registers.

Decomposition:
- Package wb_pkg:
  - DW, AW, ZERO_REG=0
  - struct wb_entry_t {waddr[AW], wdata[DW]}
  - a function for the r0-suppressed write-enable
- One sub-module, wb_fifo:
  - Synchronous FIFO parameterised by depth and wb_entry_t width.
  - Ports: push, pop, din, dout, full, empty, count.
  - Pointer wrap is handled modulo FIFO_DEPTH.
- Arbiter, scoreboard and starve counter stay in wb_arbiter.

Test Plan:
- Reset: hold rst=0 for 3 cycles with lu_valid=1, then release -> lu_ready=0 during reset; rf_we=0, rs_busy=0, stall_req=0 throughout; lu_ready=1 on the first cycle after release.
- Pipeline only: pipe_we=1, waddr=8, wdata=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0xDEADBEEF. Repeat with waddr=0 -> rf_we=0.
- Long-latency path:
  - issue_valid with waddr=5 -> rs_busy=1 for rs_addr=5 from the next cycle.
  - Push lu (5, 0x1234) with pipe idle -> rf_we=1, rf_waddr=5 two cycles after the push; busy[5] clears in the same cycle rf_we rises.
- Collision and starvation: FIFO holds (3, 0xA), pipe_we=1 continuously -> rf writes carry pipe data only, and stall_req=1 after 4 cycles. Drop pipe_we for 1 cycle -> rf_waddr=3, rf_wdata=0xA, and stall_req falls the following cycle.
- Full FIFO: push 2 entries while pipe_we=1 -> lu_ready=0 and stall_req=1. A third lu_valid held stable is accepted only after a pop; all three retire in push order.
- Set/clear race: issue_valid with waddr=7 in the same cycle a FIFO entry for r7 pops -> busy[7] remains 1.
